// File: rtl/raymarch_pkg.sv
// raymarch_pkg: shared definitions for the sphere-tracing core.
//   - 27-bit float format: [26] sign, [25:18] exponent (bias 127), [17:0] mantissa
//   - float helpers: int-to-float, add, multiply, square root, 3-vector norm
//   - FSM state enum and scene selector codes
package raymarch_pkg;
    localparam int FPW      = 27;
    localparam int EXPW     = 8;
    localparam int MANW     = 18;
    localparam int EXP_BIAS = 127;

    typedef logic [FPW-1:0] fp_t;

    localparam fp_t FP_ZERO = 27'h0000000;
    localparam fp_t FP_ONE  = 27'h1FC0000;

    // Scene selection for rm_scene_sdf
    localparam int SCENE_SPHERE = 0;
    localparam int SCENE_PLANE  = 1;
    localparam int SCENE_CONST  = 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} rm_state_e;

    function automatic fp_t fp_neg(input fp_t a);
        return {~a[FPW-1], a[FPW-2:0]};
    endfunction

    // Unsigned integer to float; mantissa is truncated beyond 18 fraction bits.
    function automatic fp_t fp_from_int(input logic [31:0] v);
        logic [31:0] n;
        int          p;
        if (v == '0) return FP_ZERO;
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        n = v << (31 - p);
        return {1'b0, EXPW'(EXP_BIAS + p), n[30:13]};
    endfunction

    // Signed float add with three guard bits, truncating. Zero is any value
    // with a zero magnitude field; underflow flushes to zero.
    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        fp_t               big, sml;
        logic [MANW+3:0]   mb, ms;
        logic [MANW+4:0]   sum;
        int                sh, e;
        if (a[FPW-2:0] == '0) return b;
        if (b[FPW-2:0] == '0) return a;
        if (a[FPW-2:0] >= b[FPW-2:0]) begin
            big = a; sml = b;
        end else begin
            big = b; sml = a;
        end
        mb = {1'b1, big[MANW-1:0], 3'b000};
        ms = {1'b1, sml[MANW-1:0], 3'b000};
        e  = int'(big[FPW-2:MANW]);
        sh = e - int'(sml[FPW-2:MANW]);
        ms = (sh > MANW + 3) ? '0 : (ms >> sh);
        if (big[FPW-1] == sml[FPW-1]) sum = {1'b0, mb} + {1'b0, ms};
        else                          sum = {1'b0, mb} - {1'b0, ms};
        if (sum == '0) return FP_ZERO;
        if (sum[MANW+4]) begin
            sum = sum >> 1;
            e++;
        end else begin
            for (int i = 0; i < MANW + 4; i++) begin
                if (!sum[MANW+3]) begin
                    sum = sum << 1;
                    e--;
                end
            end
        end
        if (e <= 0) return FP_ZERO;
        if (e > 255) e = 255;
        return {big[FPW-1], EXPW'(e), sum[MANW+2:3]};
    endfunction

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic [2*MANW+1:0] p;
        logic [MANW-1:0]   m;
        int                e;
        if (a[FPW-2:MANW] == '0 || b[FPW-2:MANW] == '0) return FP_ZERO;
        p = (2*MANW+2)'({1'b1, a[MANW-1:0]}) * (2*MANW+2)'({1'b1, b[MANW-1:0]});
        e = int'(a[FPW-2:MANW]) + int'(b[FPW-2:MANW]) - EXP_BIAS;
        if (p[2*MANW+1]) begin
            m = p[2*MANW:MANW+1];
            e++;
        end else begin
            m = p[2*MANW-1:MANW];
        end
        if (e <= 0) return FP_ZERO;
        if (e > 255) e = 255;
        return {a[FPW-1] ^ b[FPW-1], EXPW'(e), m};
    endfunction

    // Square root: halve the unbiased exponent (folding an odd one into the
    // radicand) and take a bit-serial integer root of the mantissa.
    function automatic fp_t fp_sqrt(input fp_t a);
        logic [2*MANW+1:0] rad;
        logic [MANW:0]     r, trial;
        int                e;
        if (a[FPW-1] || a[FPW-2:MANW] == '0) return FP_ZERO;
        e = int'(a[FPW-2:MANW]) - EXP_BIAS;
        if (e % 2 != 0) begin
            rad = (2*MANW+2)'({1'b1, a[MANW-1:0]}) << (MANW + 1);
            e   = e - 1;
        end else begin
            rad = (2*MANW+2)'({1'b1, a[MANW-1:0]}) << MANW;
        end
        r = '0;
        for (int i = MANW; i >= 0; i--) begin
            trial = r | ((MANW+1)'(1) << i);
            if ((2*MANW+2)'(trial) * (2*MANW+2)'(trial) <= rad) r = trial;
        end
        return {1'b0, EXPW'(e / 2 + EXP_BIAS), r[MANW-1:0]};
    endfunction

    function automatic fp_t vec_norm(input fp_t x, input fp_t y, input fp_t z);
        return fp_sqrt(fp_add(fp_add(fp_mul(x, x), fp_mul(y, y)), fp_mul(z, z)));
    endfunction
endpackage

// File: rtl/raymarch_core_sdf.sv
// rm_scene_sdf: scene signed-distance evaluator with a fixed latency.
//   clk                      clock (data pipeline only, no reset)
//   point_x/point_y/point_z  query point, 27-bit floats
//   distance                 signed distance for the point presented SDF_LAT cycles earlier
// SCENE selects the sphere scene (|p - c| - r), a plane at z = SCENE_K
// (d = SCENE_K - z), or a constant distance SCENE_K.
module rm_scene_sdf
    import raymarch_pkg::*;
#(
    parameter int             SDF_LAT = 2,
    parameter int             SCENE   = SCENE_SPHERE,
    parameter logic [FPW-1:0] SCENE_K = 27'h2090000,  // 10.0
    parameter logic [FPW-1:0] SPH_CX  = 27'h21D0000,  // 320.0
    parameter logic [FPW-1:0] SPH_CY  = 27'h21B8000,  // 240.0
    parameter logic [FPW-1:0] SPH_CZ  = 27'h21E4000,  // 400.0
    parameter logic [FPW-1:0] SPH_R   = 27'h21A4000   // 200.0
)(
    input  logic           clk,
    input  logic [FPW-1:0] point_x,
    input  logic [FPW-1:0] point_y,
    input  logic [FPW-1:0] point_z,
    output logic [FPW-1:0] distance
);
    logic [FPW-1:0] dist_d;
    logic [FPW-1:0] pipe_q [SDF_LAT];

    always_comb begin
        dist_d = FP_ZERO;
        if (SCENE == SCENE_PLANE) begin
            dist_d = fp_add(SCENE_K, fp_neg(point_z));
        end else if (SCENE == SCENE_CONST) begin
            dist_d = SCENE_K;
        end else begin
            dist_d = fp_add(vec_norm(fp_add(point_x, fp_neg(SPH_CX)),
                                     fp_add(point_y, fp_neg(SPH_CY)),
                                     fp_add(point_z, fp_neg(SPH_CZ))),
                            fp_neg(SPH_R));
        end
    end

    always_ff @(posedge clk) begin
        pipe_q[0] <= dist_d;
        for (int i = 1; i < SDF_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign distance = pipe_q[SDF_LAT-1];
endmodule

// File: rtl/raymarch_core.sv
// raymarch_core: iterative sphere tracer, one orthographic +z ray per pixel.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    pixel request handshake; pixel_x/pixel_y sampled on accept
//   out_valid/out_ready  result handshake; result held stable until taken
//   red/green/blue       gray shade (all equal)
//   out_hit              1 = surface hit, 0 = miss
//   out_steps            number of ray advances performed
module raymarch_core
    import raymarch_pkg::*;
#(
    parameter int             CORDW     = 10,
    parameter int             SDF_LAT   = 2,
    parameter int             MAX_STEPS = 32,
    parameter logic [FPW-1:0] EPS       = 27'h1F80000,  // 0.5
    parameter logic [FPW-1:0] T_MAX     = 27'h223D000,  // 1000.0
    parameter logic [FPW-1:0] CAM_Z     = 27'h0000000,  // 0.0
    parameter logic [7:0]     BG_SHADE  = 8'h00,
    parameter int             SCENE     = SCENE_SPHERE,
    parameter logic [FPW-1:0] SCENE_K   = 27'h2090000
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CORDW-1:0]             pixel_x,
    input  logic [CORDW-1:0]             pixel_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   red,
    output logic [7:0]                   green,
    output logic [7:0]                   blue,
    output logic                         out_hit,
    output logic [$clog2(MAX_STEPS):0]   out_steps
);
    localparam int SW       = $clog2(MAX_STEPS) + 1;
    localparam int SHADE_SH = 8 - $clog2(MAX_STEPS);
    localparam int WCW      = $clog2(SDF_LAT) + 1;

    rm_state_e      state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SW-1:0]  evals_q, evals_d, adv_q, adv_d;
    logic           hit_q, hit_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     shade_q, shade_d;
    logic           out_hit_q, out_hit_d;
    logic [SW-1:0]  out_steps_q, out_steps_d;
    logic [FPW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d, d_q, d_d;

    logic [FPW-1:0] sdf_dist, t_sum, z_sum;
    logic [SW-1:0]  evals_inc;
    logic           accept, wait_last, upd_hit, upd_miss;

    function automatic logic [7:0] shade_of(input logic hit, input logic [SW-1:0] adv);
        logic [15:0] scaled;
        scaled = 16'(adv) << SHADE_SH;
        return hit ? (8'hFF - scaled[7:0]) : BG_SHADE;
    endfunction

    rm_scene_sdf #(
        .SDF_LAT (SDF_LAT),
        .SCENE   (SCENE),
        .SCENE_K (SCENE_K)
    ) u_sdf (
        .clk      (clk),
        .point_x  (x_q),
        .point_y  (y_q),
        .point_z  (z_q),
        .distance (sdf_dist)
    );

    assign accept    = in_valid && in_ready_q;
    assign wait_last = (wait_cnt_q == WCW'(SDF_LAT - 1));
    assign evals_inc = evals_q + SW'(1);
    assign t_sum     = fp_add(t_q, d_q);
    assign z_sum     = fp_add(z_q, d_q);
    // Hit check takes priority over the step/distance limits.
    assign upd_hit   = d_q[FPW-1] || (d_q[FPW-2:0] < EPS[FPW-2:0]);
    assign upd_miss  = (t_sum[FPW-2:0] > T_MAX[FPW-2:0]) || (evals_inc == SW'(MAX_STEPS));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_last) state_d = UPDATE;
            UPDATE:  state_d = (upd_hit || upd_miss) ? DONE : ISSUE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // in_ready is registered so it stays low through reset and the
        // result-handshake cycle.
        in_ready_d  = (state_d == IDLE);
        wait_cnt_d  = wait_cnt_q;
        evals_d     = evals_q;
        adv_d       = adv_q;
        hit_d       = hit_q;
        out_valid_d = out_valid_q;
        shade_d     = shade_q;
        out_hit_d   = out_hit_q;
        out_steps_d = out_steps_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        t_d = t_q;
        d_d = d_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = fp_from_int(32'(pixel_x));
                    y_d     = fp_from_int(32'(pixel_y));
                    z_d     = CAM_Z;
                    t_d     = FP_ZERO;
                    evals_d = '0;
                    adv_d   = '0;
                    hit_d   = 1'b0;
                end
            end
            ISSUE: wait_cnt_d = '0;
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
                if (wait_last) d_d = sdf_dist;
            end
            UPDATE: begin
                evals_d = evals_inc;
                if (upd_hit) begin
                    hit_d = 1'b1;
                end else begin
                    t_d   = t_sum;
                    z_d   = z_sum;
                    adv_d = adv_q + SW'(1);
                end
            end
            DONE: begin
                // First DONE cycle registers the result; it then holds until taken.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    shade_d     = shade_of(hit_q, adv_q);
                    out_hit_d   = hit_q;
                    out_steps_d = adv_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            wait_cnt_q  <= '0;
            evals_q     <= '0;
            adv_q       <= '0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b0;
            shade_q     <= 8'h00;
            out_hit_q   <= 1'b0;
            out_steps_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            wait_cnt_q  <= wait_cnt_d;
            evals_q     <= evals_d;
            adv_q       <= adv_d;
            hit_q       <= hit_d;
            out_valid_q <= out_valid_d;
            shade_q     <= shade_d;
            out_hit_q   <= out_hit_d;
            out_steps_q <= out_steps_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
        t_q <= t_d;
        d_q <= d_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign red       = shade_q;
    assign green     = shade_q;
    assign blue      = shade_q;
    assign out_hit   = out_hit_q;
    assign out_steps = out_steps_q;
endmodule

// File: tb/tb_raymarch_core.sv
// Directed bench for raymarch_core with four scene instances:
//   0: plane d = 10.0 - z, 1: constant 1.0, 2: constant 600.0, 3: constant -3.0
module tb_raymarch_core;
    import raymarch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv   [4];
    logic       ordy [4];
    logic [9:0] px   [4];
    logic [9:0] py   [4];
    logic       ird  [4];
    logic       ov   [4];
    logic       ohit [4];
    logic [7:0] r    [4];
    logic [7:0] gr   [4];
    logic [7:0] b    [4];
    logic [5:0] st   [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int             SC = (g == 0) ? SCENE_PLANE : SCENE_CONST;
        localparam logic [26:0]    KV = (g == 0) ? 27'h2090000 :   // 10.0
                                        (g == 1) ? 27'h1FC0000 :   // 1.0
                                        (g == 2) ? 27'h220B000 :   // 600.0
                                                   27'h6020000;    // -3.0
        raymarch_core #(
            .CORDW(10), .SDF_LAT(2), .MAX_STEPS(32),
            .EPS(27'h1F80000), .T_MAX(27'h223D000), .CAM_Z(27'h0000000),
            .BG_SHADE(8'h00), .SCENE(SC), .SCENE_K(KV)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ird[g]),
            .pixel_x   (px[g]),
            .pixel_y   (py[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .red       (r[g]),
            .green     (gr[g]),
            .blue      (b[g]),
            .out_hit   (ohit[g]),
            .out_steps (st[g])
        );
    end

    typedef struct {
        int         k;
        int         x;
        int         y;
        bit         hit;
        int         steps;
        logic [7:0] shade;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int w;
        int cyc;
        w = 0;
        while (!ird[v.k] && w < 20) begin
            tick();
            w++;
        end
        chk($sformatf("v%0d_ready_before", idx), 32'(ird[v.k]), 1);
        px[v.k] = 10'(v.x);
        py[v.k] = 10'(v.y);
        iv[v.k] = 1'b1;
        tick();
        iv[v.k] = 1'b0;
        cyc = 0;
        while (!ov[v.k] && cyc < 300) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d_hit", idx), 32'(ohit[v.k]), 32'(v.hit));
        chk($sformatf("v%0d_steps", idx), 32'(st[v.k]), 32'(v.steps));
        chk($sformatf("v%0d_red", idx), 32'(r[v.k]), 32'(v.shade));
        chk($sformatf("v%0d_green_blue", idx), {16'h0, gr[v.k], b[v.k]}, {16'h0, v.shade, v.shade});
        ordy[v.k] = 1'b1;
        tick();
        ordy[v.k] = 1'b0;
        chk($sformatf("v%0d_ready_after", idx), 32'(ird[v.k]), 1);
        chk($sformatf("v%0d_valid_after", idx), 32'(ov[v.k]), 0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; px[i] = '0; py[i] = '0;
        end
        vecs[0] = '{k: 0, x: 5,    y: 7,    hit: 1, steps: 1,  shade: 8'hF7, lat: 9};
        vecs[1] = '{k: 0, x: 0,    y: 0,    hit: 1, steps: 1,  shade: 8'hF7, lat: 9};
        vecs[2] = '{k: 1, x: 1023, y: 1023, hit: 0, steps: 32, shade: 8'h00, lat: 129};
        vecs[3] = '{k: 2, x: 3,    y: 4,    hit: 0, steps: 2,  shade: 8'h00, lat: 9};
        vecs[4] = '{k: 3, x: 5,    y: 7,    hit: 1, steps: 0,  shade: 8'hFF, lat: 5};
        vecs[5] = '{k: 3, x: 640,  y: 480,  hit: 1, steps: 0,  shade: 8'hFF, lat: 5};

        // Reset state
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(ird[0]), 0);
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_shade", 32'(r[0]), 0);
        chk("rst_hit_steps", {31'h0, ohit[0]} | 32'(st[0]), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 32'(ird[0]), 0);
        tick();
        chk("rel_in_ready", 32'(ird[0]), 1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // DONE held with out_ready low; in_valid pulses must be ignored
        px[0] = 10'd5; py[0] = 10'd7; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        w = 0;
        while (!ov[0] && w < 50) begin
            tick();
            w++;
        end
        chk("hold_latency", 32'(w), 9);
        for (int i = 0; i < 10; i++) begin
            iv[0] = (i % 2 == 0);
            px[0] = 10'd100;
            tick();
            chk($sformatf("hold%0d_valid", i), 32'(ov[0]), 1);
            chk($sformatf("hold%0d_in_ready", i), 32'(ird[0]), 0);
            chk($sformatf("hold%0d_shade", i), 32'(r[0]), 32'h00F7);
            chk($sformatf("hold%0d_hit_steps", i), {ohit[0], 26'h0, st[0]}, {1'b1, 26'h0, 6'd1});
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("hold_ready_next", 32'(ird[0]), 1);
        for (int i = 0; i < 8; i++) tick();
        chk("hold_no_phantom", 32'(ov[0]), 0);

        // Reset during WAIT of the second evaluation
        px[0] = 10'd5; py[0] = 10'd7; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(ov[0]), 0);
        chk("abort_in_ready", 32'(ird[0]), 0);
        chk("abort_outputs", {8'h0, r[0], gr[0], b[0]} | 32'(st[0]) | 32'(ohit[0]), 0);
        tick(); tick();
        chk("abort_valid_held", 32'(ov[0]), 0);
        rst_n = 1'b1;
        tick();
        chk("abort_ready_after", 32'(ird[0]), 1);
        run_vec(6, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
